packet_serializer: RTL
======================

PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 Parameter: HALF_BIT_CYCLES, default 4, clocks per Manchester half-bit (legal range 2..255).
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 n_rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  frame request; sampled only in IDLE.
REQ-005 pkt_len  in  8  payload byte count, latched with start.
REQ-006 fifo_empty  in  1  source FIFO empty flag.
REQ-007 fifo_data  in  8  FIFO head word (first-word-fall-through), valid whenever fifo_empty=0.
REQ-008 fifo_r_en  out  1  one-cycle pop strobe; the byte is consumed on the same edge.
REQ-009 ethernet_out  out  1  registered Manchester line output; idle low.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse on normal frame completion.
REQ-012 underrun  out  1  one-cycle pulse on frame abort due to fifo_empty.

Function
REQ-013 States: IDLE, PREAMBLE, SFD, PAYLOAD, CRC (only when CRC is compiled in, see REQ-027).
REQ-014 IDLE -> PREAMBLE when start=1 and pkt_len!=0. Latch pkt_len. start with pkt_len=0 is ignored. start outside IDLE is ignored.
REQ-015 The first half-bit appears on ethernet_out in the cycle after start is sampled.
REQ-016 PREAMBLE sends 7 bytes of 0x55, then SFD sends 1 byte of 0xD5, then PAYLOAD sends pkt_len bytes from the FIFO.
REQ-017 Every byte is sent LSB first. One bit lasts 2*HALF_BIT_CYCLES cycles.
REQ-018 Manchester coding: bit 1 is low half then high half; bit 0 is high half then low half.
REQ-019 Fetch rule:
  - Each payload byte is fetched in the last cycle of the preceding byte (SFD or previous payload byte).
  - If fifo_empty=0: assert fifo_r_en for that cycle and load the shift register from fifo_data.
  - Result: no gap between bytes.
REQ-020 Underrun:
  - If fifo_empty=1 at a fetch cycle: pulse underrun, drive ethernet_out low next cycle, return to IDLE.
  - No fifo_r_en and no done in this case.
REQ-021 Completion: after the last half-bit of the final byte, return to IDLE, drive ethernet_out low and pulse done in the same cycle.
REQ-022 fifo_r_en is never asserted while fifo_empty=1, and never outside PAYLOAD fetch cycles.
REQ-023 Counters:
  - Half-bit counter: 8-bit.
  - Bit counter: 3-bit, wraps 7->0 at the byte boundary.
  - Byte counter: 8-bit down-counter from pkt_len.
  - pkt_len=255 is legal.
REQ-024 Frame length: (8+N)*16*HALF_BIT_CYCLES cycles for N payload bytes (plus one byte with CRC). busy is high for exactly that many cycles.
REQ-025 A new start is accepted in the cycle after done or underrun (back-to-back frames).

Reset
REQ-026 While n_rst=0:
  - State is IDLE and all counters are zero.
  - ethernet_out, fifo_r_en, busy, done and underrun are 0.
  - This applies immediately, including mid-frame.
  - The first start is accepted on the first rising edge after n_rst is released.

Configuration
REQ-027 Macro PACKET_SERIALIZER_CRC_EN:
  - Defined: after the last payload byte, enter CRC and send one CRC-8 byte.
  - CRC-8: polynomial 0x07, init 0x00, computed MSB-first over the payload bytes, no reflection, no final XOR.
  - The CRC byte is transmitted LSB first.
  - Not defined: the CRC state and CRC logic are absent, and PAYLOAD goes directly to IDLE.

Verification
REQ-028 Reset mid-preamble (HALF_BIT_CYCLES=4): assert n_rst=0 -> ethernet_out=0 and busy=0 asynchronously; the next start frames correctly.
REQ-029 Single payload byte 0xA5, HALF_BIT_CYCLES=4, CRC macro undefined:
  - Line decodes to 7x0x55, 0xD5, 0xA5.
  - busy is high for 576 cycles; done pulses once.
  - fifo_r_en pulses exactly once.
REQ-030 Same stimulus with PACKET_SERIALIZER_CRC_EN defined -> trailing byte 0x72; busy is high for 640 cycles.
REQ-031 pkt_len=3, FIFO holds only 2 bytes:
  - Two fifo_r_en pulses.
  - underrun pulses at the third byte boundary; done is never asserted.
  - Line returns low.
REQ-032 start with pkt_len=0 -> busy stays 0, no fifo_r_en, no line activity.
REQ-033 Two frames of pkt_len=2 with start asserted the cycle after the first done -> second preamble starts with no idle gap beyond one cycle; fifo_r_en total 4.

Source files
------------

// File: rtl/packet_serializer.sv
// Manchester frame serializer: 7x0x55 preamble, 0xD5 SFD, pkt_len FIFO bytes, LSB first; optional CRC-8 trailer
// when PACKET_SERIALIZER_CRC_EN is defined. First half-bit one cycle after start; FIFO pops only at byte boundaries.
module packet_serializer #(
    parameter int unsigned HALF_BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [7:0] pkt_len,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_r_en,
    output logic       ethernet_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

`ifdef PACKET_SERIALIZER_CRC_EN
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, CRC} state_t;
`else
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD} state_t;
`endif

    localparam logic [7:0] HALF_LAST = 8'(HALF_BIT_CYCLES - 1);

    state_t     state_q;
    logic [7:0] half_cnt_q;
    logic       phase_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_cnt_q;
    logic [7:0] len_q;
    logic [7:0] shift_q;
    logic       line_q;
    logic       busy_q;
    logic       done_q;
    logic       underrun_q;
    logic       half_end;
    logic       byte_end;
    logic       fetch;

`ifdef PACKET_SERIALIZER_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    assign crc_d = crc8_step(crc_q, fifo_data);
`endif

    assign half_end  = (half_cnt_q == HALF_LAST);
    assign byte_end  = half_end && phase_q && (bit_cnt_q == 3'd7);
    // byte_cnt_q holds payload bytes still to fetch once past the preamble
    assign fetch     = byte_end && ((state_q == SFD) || ((state_q == PAYLOAD) && (byte_cnt_q != 8'd0)));
    assign fifo_r_en = fetch && !fifo_empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            half_cnt_q <= 8'd0;
            phase_q    <= 1'b0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            len_q      <= 8'd0;
            shift_q    <= 8'd0;
            line_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef PACKET_SERIALIZER_CRC_EN
            crc_q      <= 8'd0;
`endif
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start && (pkt_len != 8'd0)) begin
                    state_q    <= PREAMBLE;
                    len_q      <= pkt_len;
                    byte_cnt_q <= 8'd6;
                    shift_q    <= 8'h55;
                    line_q     <= 1'b0;
                    busy_q     <= 1'b1;
                    half_cnt_q <= 8'd0;
                    phase_q    <= 1'b0;
                    bit_cnt_q  <= 3'd0;
`ifdef PACKET_SERIALIZER_CRC_EN
                    crc_q      <= 8'd0;
`endif
                end
            end else if (!half_end) begin
                half_cnt_q <= half_cnt_q + 8'd1;
            end else if (!phase_q) begin
                half_cnt_q <= 8'd0;
                phase_q    <= 1'b1;
                line_q     <= shift_q[0];
            end else if (bit_cnt_q != 3'd7) begin
                half_cnt_q <= 8'd0;
                phase_q    <= 1'b0;
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                shift_q    <= shift_q >> 1;
                line_q     <= ~shift_q[1];
            end else begin
                half_cnt_q <= 8'd0;
                phase_q    <= 1'b0;
                bit_cnt_q  <= 3'd0;
                if (state_q == PREAMBLE) begin
                    if (byte_cnt_q == 8'd0) begin
                        state_q    <= SFD;
                        shift_q    <= 8'hD5;
                        line_q     <= 1'b0;
                        byte_cnt_q <= len_q;
                    end else begin
                        byte_cnt_q <= byte_cnt_q - 8'd1;
                        shift_q    <= 8'h55;
                        line_q     <= 1'b0;
                    end
                end else if (fetch) begin
                    if (fifo_empty) begin
                        state_q    <= IDLE;
                        line_q     <= 1'b0;
                        busy_q     <= 1'b0;
                        underrun_q <= 1'b1;
                        byte_cnt_q <= 8'd0;
                    end else begin
                        state_q    <= PAYLOAD;
                        shift_q    <= fifo_data;
                        line_q     <= ~fifo_data[0];
                        byte_cnt_q <= byte_cnt_q - 8'd1;
`ifdef PACKET_SERIALIZER_CRC_EN
                        crc_q      <= crc_d;
`endif
                    end
                end
`ifdef PACKET_SERIALIZER_CRC_EN
                else if (state_q == PAYLOAD) begin
                    state_q <= CRC;
                    shift_q <= crc_q;
                    line_q  <= ~crc_q[0];
                end
`endif
                else begin
                    state_q <= IDLE;
                    line_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign ethernet_out = line_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign underrun     = underrun_q;

endmodule
